// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: passive consumer of an HD44780-style 8-bit LCD bus.
// Decodes write strobes into commands or characters, keeps a 2x16 DDRAM
// mirror with HD44780 address-counter behaviour, models controller busy
// time and raises a sticky flag when a strobe arrives while busy.
module lcd_bus_receiver #(
   parameter int BUSY_CYCLES  = 2000,   // busy time after a normal byte
   parameter int CLEAR_CYCLES = 82000   // busy time after clear/home, >= 33
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic       iLCD_EN,
   input  logic       iLCD_RS,
   input  logic       iLCD_RW,
   input  logic [7:0] iLCD_DATA,
   input  logic [4:0] iRD_ADDR,
   output logic [7:0] oRD_CHAR,
   output logic       oCMD_VALID,
   output logic       oCMD_RS,
   output logic [7:0] oCMD_BYTE,
   output logic [6:0] oADDR,
   output logic       oDISPLAY_ON,
   output logic       oBUSY,
   output logic       oPROTO_ERR
);

   localparam int MAX_CYCLES = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES);
   localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES);
   localparam logic [7:0]    BLANK      = 8'h20;

   // Instruction class, selected by the highest set bit of a command byte.
   typedef enum logic [3:0] {
      K_NOP, K_CLEAR, K_HOME, K_ENTRY, K_DISPLAY,
      K_SHIFT, K_FUNC, K_CGRAM, K_DDRAM
   } cmd_kind_e;

   // Bus synchronizers and captured byte
   logic       en_s1, en_s2, en_d;
   logic       rs_s1, rs_s2;
   logic       rw_s1, rw_s2;
   logic [7:0] data_s1, data_s2;
   logic       cap_rs, cap_rw;
   logic [7:0] cap_data;

   // Controller state
   logic          inc_dec;       // I/D: 1 = increment
   logic          cg_mode;       // data writes go to CGRAM (discarded)
   logic [CW-1:0] busy_cnt;
   logic          fill_active;
   logic [4:0]    fill_idx;
   logic [7:0]    mirror [32];

   logic       fall, accept, reject, data_wr, ac_mirrored;
   logic [4:0] ac_idx;
   cmd_kind_e  cmd_kind;

   // Next address-counter value after one step, with the HD44780 two-line wrap.
   function automatic logic [6:0] step_ac(input logic [6:0] ac, input logic up);
      logic [6:0] nxt;
      if (up) begin
         if (ac == 7'h27)      nxt = 7'h40;
         else if (ac == 7'h67) nxt = 7'h00;
         else                  nxt = ac + 7'd1;
      end else begin
         if (ac == 7'h40)      nxt = 7'h27;
         else if (ac == 7'h00) nxt = 7'h67;
         else                  nxt = ac - 7'd1;
      end
      return nxt;
   endfunction

   // Double-flop the asynchronous bus and hold the byte seen while EN is high.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         en_s1    <= 1'b0;
         en_s2    <= 1'b0;
         en_d     <= 1'b0;
         rs_s1    <= 1'b0;
         rs_s2    <= 1'b0;
         rw_s1    <= 1'b0;
         rw_s2    <= 1'b0;
         data_s1  <= 8'h00;
         data_s2  <= 8'h00;
         cap_rs   <= 1'b0;
         cap_rw   <= 1'b0;
         cap_data <= 8'h00;
      end else begin
         // NOTE: non-blocking so each stage samples its pre-edge input;
         // blocking assignments here would collapse the chain into one flop.
         en_s1   <= iLCD_EN;
         en_s2   <= en_s1;
         en_d    <= en_s2;
         rs_s1   <= iLCD_RS;
         rs_s2   <= rs_s1;
         rw_s1   <= iLCD_RW;
         rw_s2   <= rw_s1;
         data_s1 <= iLCD_DATA;
         data_s2 <= data_s1;
         if (en_s2) begin
            cap_rs   <= rs_s2;
            cap_rw   <= rw_s2;
            cap_data <= data_s2;
         end
      end
   end

   assign fall        = en_d & ~en_s2;
   assign oBUSY       = (busy_cnt != '0) | fill_active;
   assign accept      = fall & ~cap_rw & ~oBUSY;
   assign reject      = fall & ~cap_rw & oBUSY;
   assign ac_mirrored = (oADDR[6:4] == 3'b000) | (oADDR[6:4] == 3'b100);
   assign ac_idx      = {oADDR[6], oADDR[3:0]};
   assign data_wr     = accept & cap_rs & ~cg_mode & ac_mirrored;

   // Classify the captured command byte by its highest set bit.
   always_comb begin
      // NOTE: default first so every path assigns cmd_kind and no latch is inferred.
      cmd_kind = K_NOP;
      casez (cap_data)
         8'b1???????: cmd_kind = K_DDRAM;
         8'b01??????: cmd_kind = K_CGRAM;
         8'b001?????: cmd_kind = K_FUNC;
         8'b0001????: cmd_kind = K_SHIFT;
         8'b00001???: cmd_kind = K_DISPLAY;
         8'b000001??: cmd_kind = K_ENTRY;
         8'b0000001?: cmd_kind = K_HOME;
         8'b00000001: cmd_kind = K_CLEAR;
         default:     cmd_kind = K_NOP;
      endcase
   end

   // Accept or reject strobes, run the busy timer and update controller state.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         oCMD_VALID  <= 1'b0;
         oCMD_RS     <= 1'b0;
         oCMD_BYTE   <= 8'h00;
         oADDR       <= 7'h00;
         oDISPLAY_ON <= 1'b0;
         oPROTO_ERR  <= 1'b0;
         inc_dec     <= 1'b1;
         cg_mode     <= 1'b0;
         busy_cnt    <= '0;
         fill_active <= 1'b0;
         fill_idx    <= 5'd0;
      end else begin
         oCMD_VALID <= accept;
         if (reject)
            oPROTO_ERR <= 1'b1;
         if (busy_cnt != '0)
            busy_cnt <= busy_cnt - CW'(1);
         if (fill_active) begin
            fill_idx <= fill_idx + 5'd1;
            if (fill_idx == 5'd31)
               fill_active <= 1'b0;
         end
         if (accept) begin
            oCMD_RS   <= cap_rs;
            oCMD_BYTE <= cap_data;
            busy_cnt  <= (!cap_rs && (cmd_kind == K_CLEAR || cmd_kind == K_HOME))
                         ? CLEAR_LOAD : BUSY_LOAD;
            if (cap_rs) begin
               if (!cg_mode)
                  oADDR <= step_ac(oADDR, inc_dec);
            end else begin
               case (cmd_kind)
                  K_CLEAR: begin
                     oADDR       <= 7'h00;
                     inc_dec     <= 1'b1;
                     cg_mode     <= 1'b0;
                     fill_active <= 1'b1;
                     fill_idx    <= 5'd0;
                  end
                  K_HOME:    oADDR       <= 7'h00;
                  K_ENTRY:   inc_dec     <= cap_data[1];
                  K_DISPLAY: oDISPLAY_ON <= cap_data[2];
                  K_SHIFT: begin
                     if (!cap_data[3])
                        oADDR <= step_ac(oADDR, cap_data[2]);
                  end
                  K_CGRAM:   cg_mode <= 1'b1;
                  K_DDRAM: begin
                     oADDR   <= cap_data[6:0];
                     cg_mode <= 1'b0;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // Mirror storage: clear fill or character write, plus the registered read port.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         // NOTE: the mirror must come up as blank text, so it is a flop array
         // with an explicit reset rather than an inferred RAM.
         for (int i = 0; i < 32; i++)
            mirror[i] <= BLANK;
         oRD_CHAR <= BLANK;
      end else begin
         if (fill_active)
            mirror[fill_idx] <= BLANK;
         else if (data_wr)
            mirror[ac_idx] <= cap_data;
         oRD_CHAR <= mirror[iRD_ADDR];
      end
   end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Testbench for lcd_bus_receiver: directed scenarios plus randomized strobes,
// checked every cycle against a behavioural model of the LCD controller.
module tb_lcd_bus_receiver;

   localparam int B = 40;    // BUSY_CYCLES used for this bench
   localparam int C = 100;   // CLEAR_CYCLES used for this bench

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       lcd_en = 1'b0;
   logic       lcd_rs = 1'b0;
   logic       lcd_rw = 1'b0;
   logic [7:0] lcd_data = 8'h00;
   logic [4:0] rd_addr = 5'd0;
   logic [7:0] rd_char;
   logic       cmd_valid;
   logic       cmd_rs;
   logic [7:0] cmd_byte;
   logic [6:0] addr;
   logic       display_on;
   logic       busy;
   logic       proto_err;

   lcd_bus_receiver #(.BUSY_CYCLES(B), .CLEAR_CYCLES(C)) dut (
      .iCLK        (clk),
      .iRST_N      (rst_n),
      .iLCD_EN     (lcd_en),
      .iLCD_RS     (lcd_rs),
      .iLCD_RW     (lcd_rw),
      .iLCD_DATA   (lcd_data),
      .iRD_ADDR    (rd_addr),
      .oRD_CHAR    (rd_char),
      .oCMD_VALID  (cmd_valid),
      .oCMD_RS     (cmd_rs),
      .oCMD_BYTE   (cmd_byte),
      .oADDR       (addr),
      .oDISPLAY_ON (display_on),
      .oBUSY       (busy),
      .oPROTO_ERR  (proto_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      bit         rs;
      logic [7:0] b;
   } cmd_t;

   logic [7:0] m_mem [32];
   int   m_ac;
   bit   m_id, m_cg, m_disp, m_err;
   int   busy_left;
   bit   strobe_active;
   int   pulses;
   int   last_pulse_cyc;
   cmd_t exp_q [$];

   function automatic int step(input int a, input bit up);
      if (up) return (a == 'h27) ? 'h40 : (a == 'h67) ? 0 : (a + 1) % 128;
      else    return (a == 'h40) ? 'h27 : (a == 0) ? 'h67 : (a + 127) % 128;
   endfunction

   function automatic int cell_of(input int a);
      if (a < 16) return a;
      if (a >= 'h40 && a < 'h50) return a - 'h40 + 16;
      return -1;
   endfunction

   function automatic int msb_of(input logic [7:0] b);
      for (int i = 7; i >= 0; i--)
         if (b[i]) return i;
      return -1;
   endfunction

   // Applies one accepted byte; returns the busy time it starts.
   function automatic int apply_model(input cmd_t c);
      int idx;
      int m;
      if (c.rs) begin
         if (!m_cg) begin
            idx = cell_of(m_ac);
            if (idx >= 0) m_mem[idx] = c.b;
            m_ac = step(m_ac, m_id);
         end
         return B;
      end
      m = msb_of(c.b);
      case (m)
         7: begin m_ac = int'(c.b) % 128; m_cg = 0; end
         6: m_cg = 1;
         4: if (!c.b[3]) m_ac = step(m_ac, c.b[2]);
         3: m_disp = c.b[2];
         2: m_id = c.b[1];
         1: m_ac = 0;
         0: begin
            m_ac = 0; m_id = 1; m_cg = 0;
            for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
         end
         default: ;
      endcase
      return (m == 0 || m == 1) ? C : B;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
      m_ac = 0; m_id = 1; m_cg = 0; m_disp = 0; m_err = 0;
      busy_left = 0; pulses = 0; strobe_active = 0;
      exp_q.delete();
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      cmd_t e;
      if (rst_n) begin
         if (cmd_valid) begin
            pulses++;
            check("pending_on_valid", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("cmd_rs", cmd_rs, e.rs);
               check("cmd_byte", cmd_byte, e.b);
               busy_left = apply_model(e);
               last_pulse_cyc = cyc;
            end
         end
         check("addr", addr, m_ac);
         check("display_on", display_on, m_disp);
         check("busy", busy, busy_left > 0);
         if (!strobe_active) check("proto_err", proto_err, m_err);
         if (busy_left > 0) busy_left--;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_idle();
      for (int i = 0; i < 1000 && (busy_left > 0 || busy); i++) @(negedge clk);
      check("idle_timeout", busy, 0);
   endtask

   task automatic send(input bit rs, input bit rw, input logic [7:0] d);
      bit   drop;
      cmd_t c;
      @(negedge clk);
      if (busy_left > 0 && busy_left < 15) wait_idle();
      drop = !rw && busy_left > 0;
      lcd_rs = rs; lcd_rw = rw; lcd_data = d;
      strobe_active = 1;
      if (!rw && !drop) begin
         c.rs = rs; c.b = d;
         exp_q.push_back(c);
      end
      lcd_en = 1'b1;
      repeat (4) @(negedge clk);
      lcd_en = 1'b0;
      lcd_data = 8'($urandom);   // bus garbage after the fall must be ignored
      lcd_rs = 1'($urandom);
      lcd_rw = 1'($urandom);
      repeat (5) @(negedge clk);
      #1;
      check("cmd_valid_latency", exp_q.size(), 0);
      exp_q.delete();
      if (drop) m_err = 1;
      lcd_rw = 1'b0;
      strobe_active = 0;
   endtask

   task automatic read_cell(input int idx, output logic [7:0] v);
      @(negedge clk);
      rd_addr = 5'(idx);
      @(negedge clk);
      v = rd_char;
   endtask

   task automatic check_cell(input int idx);
      logic [7:0] v;
      read_cell(idx, v);
      check($sformatf("cell%0d", idx), v, m_mem[idx]);
   endtask

   task automatic read_all();
      for (int i = 0; i < 32; i++) check_cell(i);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] v;
      int r, a, n_busy;
      logic [7:0] d;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_proto_err", proto_err, 0);
      check("rst_addr", addr, 0);
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_cmd_rs", cmd_rs, 0);
      check("rst_cmd_byte", cmd_byte, 8'h00);
      check("rst_rd_char", rd_char, 8'h20);
      check("rst_display_on", display_on, 0);
      rst_n = 1'b1;
      read_all();

      // Set DDRAM 0, write 'A'
      send(0, 0, 8'h80); wait_idle();
      send(1, 0, 8'h41); wait_idle();
      check("a_addr", addr, 7'h01);
      read_cell(0, v);
      check("a_cell0", v, 8'h41);
      check("a_pulses", pulses, 2);
      check("a_last_rs", cmd_rs, 1);
      check("a_last_byte", cmd_byte, 8'h41);

      // Write at unmirrored 0x27 wraps to line 2
      send(0, 0, 8'hA7); wait_idle();
      send(1, 0, 8'h5A); wait_idle();
      check("wrap_addr", addr, 7'h40);
      read_cell(16, v);
      check("wrap_cell16_blank", v, 8'h20);
      send(1, 0, 8'h31); wait_idle();
      read_cell(16, v);
      check("wrap_cell16", v, 8'h31);
      check("wrap_addr2", addr, 7'h41);

      // Decrement wrap, then clear
      send(0, 0, 8'h04); wait_idle();
      send(0, 0, 8'h80); wait_idle();
      send(1, 0, 8'h30); wait_idle();
      check("dec_addr", addr, 7'h67);
      read_cell(0, v);
      check("dec_cell0", v, 8'h30);
      send(0, 0, 8'h01);
      for (int i = 0; i < 400 && busy; i++) @(negedge clk);
      check("clear_busy_len", cyc - last_pulse_cyc, C);
      wait_idle();
      read_all();
      check("clear_addr", addr, 7'h00);

      // Display on, then a strobe while busy
      send(0, 0, 8'h0C);
      send(1, 0, 8'h55);
      check("disp_on", display_on, 1);
      check("busy_err", proto_err, 1);
      wait_idle();
      send(0, 0, 8'h06); wait_idle();
      check("err_sticky", proto_err, 1);

      // Reset in the middle of a clear fill
      send(0, 0, 8'hC4); wait_idle();
      send(1, 0, 8'h4B); wait_idle();
      send(0, 0, 8'h01);
      for (int i = 0; i < 50 && cyc < last_pulse_cyc + 10; i++) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midfill_busy", busy, 0);
      check("midfill_err", proto_err, 0);
      check("midfill_addr", addr, 7'h00);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      read_all();

      // Randomized traffic
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 3) != 0) wait_idle();
         r = $urandom_range(0, 99);
         if (r < 30) send(1, 0, 8'($urandom));
         else if (r < 45) begin
            a = ($urandom_range(0, 1) ? 'h40 : 0) + $urandom_range(0, 19);
            if ($urandom_range(0, 9) == 0) a = $urandom_range(0, 127);
            d = 8'(8'h80 | a);
            send(0, 0, d);
         end
         else if (r < 55) send(0, 0, 8'(8'h04 | $urandom_range(0, 3)));
         else if (r < 65) send(0, 0, 8'(8'h10 | $urandom_range(0, 15)));
         else if (r < 72) send(0, 0, 8'(8'h08 | $urandom_range(0, 7)));
         else if (r < 76) send(0, 0, 8'(8'h40 | $urandom_range(0, 63)));
         else if (r < 79) send(0, 0, 8'(8'h20 | $urandom_range(0, 31)));
         else if (r < 81) send(0, 0, 8'h01);
         else if (r < 83) send(0, 0, 8'(8'h02 | $urandom_range(0, 1)));
         else if (r < 85) send(0, 0, 8'h00);
         else send($urandom_range(0, 1) != 0, 1, 8'($urandom));
         if ($urandom_range(0, 4) == 0) begin
            wait_idle();
            check_cell($urandom_range(0, 31));
         end
      end
      wait_idle();
      read_all();
      n_busy = errors;
      $display("CHECKS %0d ERRORS %0d", checks, n_busy);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
